pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/lifo_n.sv | 53 +++++
 rtl/pc_unit.sv | 143 ++++++++++++++
 tb/tb_pc_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
// PC_UNIT_INT_EN (defined elsewhere) enables the interrupt path in pc_unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_JMP,
    SRC_CALL,
    SRC_RET,
    SRC_INT
  } pc_src_e;

  // Sliced down to PC_W bits by the instantiating module.
  localparam logic [31:0] DEFAULT_INT_VEC = '1;

endpackage

// File: rtl/lifo_n.sv
// Return-address stack: W-bit entries, DEPTH deep, with occupancy count.
// Contents are deliberately not reset; only the occupancy is.
module lifo_n #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int SP_W  = AW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [W-1:0]    i_din,
  output logic [W-1:0]    o_top,
  output logic [SP_W-1:0] o_sp,
  output logic            o_full,
  output logic            o_empty
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [AW-1:0]   w_wrIdx;
  logic [AW-1:0]   w_topIdx;
  logic            w_full;
  logic            w_empty;

  assign w_full   = (r_sp == SP_W'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_wrIdx  = r_sp[AW-1:0];
  assign w_topIdx = r_sp[AW-1:0] - AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_push && !w_full) begin
      r_mem[w_wrIdx] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= '0;
    end else if (i_push && !w_full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (i_pop && !w_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  assign o_top   = r_mem[w_topIdx];
  assign o_sp    = r_sp;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/pc_unit.sv
// Program counter with jump/call/return, return stack and sticky error flags.
// Define PC_UNIT_INT_EN to add the level interrupt input and in-ISR tracking.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W    = 10,
  parameter int              DEPTH   = 8,
  parameter logic [PC_W-1:0] INT_VEC = DEFAULT_INT_VEC[PC_W-1:0],
  parameter int              SP_W    = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic            i_jump,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic [PC_W-1:0] i_target,
`ifdef PC_UNIT_INT_EN
  input  logic            i_irq,
`endif
  input  logic            i_clr_err,
  output logic [PC_W-1:0] o_pc,
  output logic [SP_W-1:0] o_sp,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_ovf,
  output logic            o_unf,
  output logic            o_in_isr
);

  logic [PC_W-1:0] r_pc;
  logic            r_ovf;
  logic            r_unf;
  logic [PC_W-1:0] w_pcInc;
  logic [PC_W-1:0] w_pcNext;
  logic [PC_W-1:0] w_top;
  logic [PC_W-1:0] w_pushData;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_ovfEvent;
  logic            w_unfEvent;
  logic            w_irqAccept;
  logic            w_irqFull;
  pc_src_e         w_src;

  assign w_pcInc = r_pc + PC_W'(1);

`ifdef PC_UNIT_INT_EN
  logic r_inIsr;
  assign w_irqAccept = i_en && i_irq && !r_inIsr && !w_full;
  assign w_irqFull   = i_en && i_irq && !r_inIsr && w_full;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_inIsr <= 1'b0;
    end else if (w_src == SRC_INT) begin
      r_inIsr <= 1'b1;
    end else if (w_src == SRC_RET) begin
      r_inIsr <= 1'b0;
    end
  end
  assign o_in_isr = r_inIsr;
`else
  assign w_irqAccept = 1'b0;
  assign w_irqFull   = 1'b0;
  assign o_in_isr    = 1'b0;
`endif

  // A refused call or return stalls the PC rather than falling through.
  always_comb begin
    w_src      = SRC_HOLD;
    w_ovfEvent = w_irqFull;
    w_unfEvent = 1'b0;
    if (i_en) begin
      if (w_irqAccept) begin
        w_src = SRC_INT;
      end else if (i_ret) begin
        if (w_empty) w_unfEvent = 1'b1;
        else         w_src      = SRC_RET;
      end else if (i_call) begin
        if (w_full) w_ovfEvent = 1'b1;
        else        w_src      = SRC_CALL;
      end else if (i_jump) begin
        w_src = SRC_JMP;
      end else begin
        w_src = SRC_INC;
      end
    end
  end

  always_comb begin
    w_pcNext = r_pc;
    case (w_src)
      SRC_INC:  w_pcNext = w_pcInc;
      SRC_JMP:  w_pcNext = i_target;
      SRC_CALL: w_pcNext = i_target;
      SRC_RET:  w_pcNext = w_top;
      SRC_INT:  w_pcNext = INT_VEC;
      default:  w_pcNext = r_pc;
    endcase
  end

  // An interrupt saves the un-executed instruction; a call saves the next one.
  assign w_push     = (w_src == SRC_CALL) || (w_src == SRC_INT);
  assign w_pop      = (w_src == SRC_RET);
  assign w_pushData = (w_src == SRC_INT) ? r_pc : w_pcInc;

  lifo_n #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_pushData),
    .o_top   (w_top),
    .o_sp    (o_sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pcNext;
      r_ovf <= (r_ovf && !i_clr_err) || w_ovfEvent;
      r_unf <= (r_unf && !i_clr_err) || w_unfEvent;
    end
  end

  assign o_pc    = r_pc;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (PC_W=10, DEPTH=8).
// Interrupt vectors run only when PC_UNIT_INT_EN is defined.
module tb_pc_unit;

  logic       clk;
  logic       reset;
  logic       en;
  logic       jump;
  logic       call;
  logic       ret;
  logic       clrErr;
  logic [9:0] target;
`ifdef PC_UNIT_INT_EN
  logic       irq;
`endif
  logic [9:0] pc;
  logic [3:0] sp;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;
  logic       inIsr;

  int assertCount = 0;
  int failCount   = 0;

  pc_unit #(
    .PC_W  (10),
    .DEPTH (8)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (en),
    .i_jump    (jump),
    .i_call    (call),
    .i_ret     (ret),
    .i_target  (target),
`ifdef PC_UNIT_INT_EN
    .i_irq     (irq),
`endif
    .i_clr_err (clrErr),
    .o_pc      (pc),
    .o_sp      (sp),
    .o_full    (full),
    .o_empty   (empty),
    .o_ovf     (ovf),
    .o_unf     (unf),
    .o_in_isr  (inIsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic e, input logic j, input logic c, input logic r,
                               input logic clr, input logic [9:0] tgt);
    en = e; jump = j; call = c; ret = r; clrErr = clr; target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; jump = 1'b0; call = 1'b0; ret = 1'b0;
    clrErr = 1'b0; target = '0;
`ifdef PC_UNIT_INT_EN
    irq = 1'b0;
`endif
    #2;
    checkOutput("reset_pc", pc, 0);
    checkOutput("reset_sp", sp, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_unf", unf, 0);
    checkOutput("reset_in_isr", inIsr, 0);

    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 1; i <= 1030; i++) begin
      @(posedge clk); #1;
      checkOutput("count_pc", pc, i % 1024);
    end
    checkOutput("count_ovf", ovf, 0);
    checkOutput("count_unf", unf, 0);

    // Nested call/return
    applyStimulus(1, 1, 0, 0, 0, 10'h010);
    checkOutput("jump_pc", pc, 10'h010);
    applyStimulus(1, 0, 1, 0, 0, 10'h100);
    checkOutput("call1_pc", pc, 10'h100);
    checkOutput("call1_sp", sp, 1);
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("inc_pc", pc, 10'h101);
    applyStimulus(1, 0, 1, 0, 0, 10'h200);
    checkOutput("call2_pc", pc, 10'h200);
    checkOutput("call2_sp", sp, 2);
    applyStimulus(1, 0, 0, 1, 0, 10'h000);
    checkOutput("ret1_pc", pc, 10'h102);
    checkOutput("ret1_sp", sp, 1);
    applyStimulus(1, 0, 0, 1, 0, 10'h000);
    checkOutput("ret2_pc", pc, 10'h011);
    checkOutput("ret2_sp", sp, 0);

    // Fill the stack, then overflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 10'(10'h300 + i));
      checkOutput("fill_pc", pc, 10'h300 + i);
      checkOutput("fill_sp", sp, i + 1);
    end
    checkOutput("fill_full", full, 1);
    applyStimulus(1, 0, 1, 0, 0, 10'h3AA);
    checkOutput("ovf_pc", pc, 10'h307);
    checkOutput("ovf_sp", sp, 8);
    checkOutput("ovf_flag", ovf, 1);
    applyStimulus(0, 1, 0, 0, 1, 10'h155);
    checkOutput("clr_ovf_flag", ovf, 0);
    checkOutput("stall_pc", pc, 10'h307);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 10'h000);
      checkOutput("unwind_pc", pc, (i < 7) ? (10'h307 - i) : 10'h012);
      checkOutput("unwind_sp", sp, 7 - i);
    end
    checkOutput("unwind_empty", empty, 1);

    // Underflow, clear racing an error, call+ret together
    applyStimulus(1, 0, 0, 1, 0, 10'h000);
    checkOutput("unf_pc", pc, 10'h012);
    checkOutput("unf_flag", unf, 1);
    checkOutput("unf_sp", sp, 0);
    applyStimulus(1, 0, 0, 1, 1, 10'h000);
    checkOutput("clr_vs_unf", unf, 1);
    applyStimulus(1, 0, 0, 0, 1, 10'h000);
    checkOutput("clr_unf", unf, 0);
    checkOutput("clr_unf_pc", pc, 10'h013);
    applyStimulus(1, 0, 1, 0, 0, 10'h040);
    checkOutput("call3_pc", pc, 10'h040);
    applyStimulus(1, 1, 1, 1, 0, 10'h2AA);
    checkOutput("callret_pc", pc, 10'h014);
    checkOutput("callret_sp", sp, 0);
    checkOutput("callret_ovf", ovf, 0);
    checkOutput("callret_unf", unf, 0);
    applyStimulus(0, 1, 0, 0, 0, 10'h155);
    checkOutput("en_low_pc", pc, 10'h014);

    // Asynchronous reset mid-stream
    applyStimulus(1, 0, 1, 0, 0, 10'h050);
    applyStimulus(1, 0, 1, 0, 0, 10'h060);
    applyStimulus(1, 0, 1, 0, 0, 10'h070);
    checkOutput("pre_rst_sp", sp, 3);
    en = 1'b0; call = 1'b1;
`ifdef PC_UNIT_INT_EN
    irq = 1'b1;
`endif
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_pc", pc, 0);
    checkOutput("async_rst_sp", sp, 0);
    checkOutput("async_rst_ovf", ovf, 0);
    checkOutput("async_rst_unf", unf, 0);
    checkOutput("async_rst_isr", inIsr, 0);
    @(posedge clk); #1;
    call = 1'b0; en = 1'b1;
`ifdef PC_UNIT_INT_EN
    irq = 1'b0;
`endif
    reset = 1'b1;
    checkOutput("post_rst_pc", pc, 0);
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("post_rst_inc", pc, 1);

`ifdef PC_UNIT_INT_EN
    applyStimulus(1, 1, 0, 0, 0, 10'h020);
    checkOutput("int_jump_pc", pc, 10'h020);
    irq = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("int_pc", pc, 10'h3FF);
    checkOutput("int_in_isr", inIsr, 1);
    checkOutput("int_sp", sp, 1);
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("int_again_pc", pc, 10'h000);
    checkOutput("int_again_sp", sp, 1);
    irq = 1'b0;
    applyStimulus(1, 0, 0, 1, 0, 10'h000);
    checkOutput("int_ret_pc", pc, 10'h020);
    checkOutput("int_ret_isr", inIsr, 0);
    checkOutput("int_ret_sp", sp, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
